// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory load/store unit.
package dmem_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Per-request control carried down the response pipeline
    typedef struct packed {
        logic       valid;
        logic       err;
        logic       is_load;
        logic [2:0] funct3;
        logic [1:0] lane;
    } lsu_pipe_t;

endpackage

// File: rtl/data_mem_lsu_align.sv
// Byte-lane formatting: store enables/replication and load extraction/extension.
module lsu_align
    import dmem_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    output logic        st_misalign_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] rep;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Store side: lane enables, replicated data, alignment (also used for loads)
    always_comb begin
        st_be_o       = 4'b0000;
        rep           = st_wdata_i;
        st_misalign_o = 1'b0;
        case (st_funct3_i)
            F3_B, F3_BU: begin
                st_be_o = 4'b0001 << st_lane_i;
                rep     = {4{st_wdata_i[7:0]}};
            end
            F3_H, F3_HU: begin
                st_be_o       = 4'b0011 << st_lane_i;
                rep           = {2{st_wdata_i[15:0]}};
                st_misalign_o = st_lane_i[0];
            end
            F3_W: begin
                st_be_o       = 4'b1111;
                st_misalign_o = (st_lane_i != 2'b00);
            end
            default: ;
        endcase
        st_wdata_o = rep & {{8{st_be_o[3]}}, {8{st_be_o[2]}}, {8{st_be_o[1]}}, {8{st_be_o[0]}}};
    end

    // Load side: pick byte/half at the lane and extend
    always_comb begin
        byte_v = ld_word_i[{ld_lane_i, 3'b000} +: 8];
        half_v = ld_lane_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   ld_data_o = {24'h0, byte_v};
            F3_H:    ld_data_o = {{16{half_v[15]}}, half_v};
            F3_HU:   ld_data_o = {16'h0, half_v};
            F3_W:    ld_data_o = ld_word_i;
            default: ld_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// RV32I data memory with load/store formatting, clear sweep and fixed-latency responses.
module data_mem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);

    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam int unsigned BYTE_AW = AW + 2;

    state_e          state_q;
    logic [AW-1:0]   clr_idx_q;
    logic            req_ready_q;
    logic            busy_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [31:0]     offset_c;
    logic [AW-1:0]   word_idx_c;
    logic [1:0]      lane_c;
    logic            oor_c;
    logic            illegal_c;
    logic            misalign_c;
    logic            accept_c;
    logic            st_commit_c;
    logic [3:0]      st_be_c;
    logic [31:0]     st_data_c;
    logic [31:0]     ld_data_c;
    lsu_pipe_t       cur_c;
    logic [31:0]     cur_word_c;
    lsu_pipe_t       tail_c;
    logic [31:0]     tail_word_c;

    // Address decode; wrap below BASE_ADDR lands in the out-of-range region
    assign offset_c   = req_addr_i - BASE_ADDR;
    assign word_idx_c = offset_c[BYTE_AW-1:2];
    assign lane_c     = offset_c[1:0];
    assign oor_c      = |offset_c[31:BYTE_AW];

    // Legal funct3 set differs between loads and stores
    always_comb begin
        illegal_c = 1'b1;
        if (req_we_i) begin
            illegal_c = !(req_funct3_i inside {F3_B, F3_H, F3_W});
        end else begin
            illegal_c = !(req_funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
    end

    assign accept_c    = req_valid_i & req_ready_q & ~rst;
    assign st_commit_c = accept_c & req_we_i & ~cur_c.err;
    assign cur_word_c  = mem_q[word_idx_c];

    // Request control captured at accept
    always_comb begin
        cur_c         = '0;
        cur_c.valid   = accept_c;
        cur_c.err     = illegal_c | misalign_c | oor_c;
        cur_c.is_load = ~req_we_i;
        cur_c.funct3  = req_funct3_i;
        cur_c.lane    = lane_c;
    end

    lsu_align u_align (
        .st_funct3_i   (req_funct3_i),
        .st_lane_i     (lane_c),
        .st_wdata_i    (req_wdata_i),
        .st_be_o       (st_be_c),
        .st_wdata_o    (st_data_c),
        .st_misalign_o (misalign_c),
        .ld_funct3_i   (tail_c.funct3),
        .ld_lane_i     (tail_c.lane),
        .ld_word_i     (tail_word_c),
        .ld_data_o     (ld_data_c)
    );

    // Clear sweep / ready FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_idx_q   <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + AW'(1);
                    if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
                        state_q     <= READY;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                READY: ;
                default: begin
                    state_q     <= CLEAR;
                    clr_idx_q   <= '0;
                    req_ready_q <= 1'b0;
                    busy_q      <= 1'b1;
                end
            endcase
        end
    end

    // Array: sweep clear or byte-enabled store commit on the accept edge
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_idx_q] <= 32'h0;
        end else if (st_commit_c) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be_c[b]) begin
                    mem_q[word_idx_c][8*b +: 8] <= st_data_c[8*b +: 8];
                end
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign tail_c      = cur_c;
            assign tail_word_c = cur_word_c;
        end else begin : g_pipe
            lsu_pipe_t   pipe_q [LATENCY-1];
            logic [31:0] word_q [LATENCY-1];

            // Control shift pipeline, flushed by reset
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(LATENCY) - 1; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= cur_c;
                    for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            // Raw word shift pipeline, qualified by the control valid
            always_ff @(posedge clk) begin
                word_q[0] <= cur_word_c;
                for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                    word_q[i] <= word_q[i-1];
                end
            end

            assign tail_c      = pipe_q[LATENCY-2];
            assign tail_word_c = word_q[LATENCY-2];
        end
    endgenerate

    // Response register; data and error forced to zero outside a valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            rsp_valid_q <= tail_c.valid;
            rsp_err_q   <= tail_c.valid & tail_c.err;
            rsp_rdata_q <= (tail_c.valid & tail_c.is_load & ~tail_c.err) ? ld_data_c : 32'h0;
        end
    end

    assign req_ready_o = req_ready_q;
    assign busy_o      = busy_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomized bench for data_mem_lsu against a byte-array reference model.
module tb_data_mem_lsu;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LAT   = 3;
    localparam logic [31:0] BASE  = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;

    data_mem_lsu #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;
    bit mon_en = 1'b0;

    logic [7:0] bmem [DEPTH*4];

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];
    exp_t cur_e;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference: little-endian byte memory, sizes and alignment by plain arithmetic
    task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, output logic err, output logic [31:0] rd);
        logic [31:0] off;
        logic [31:0] v;
        int size;
        off = addr - BASE;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        err = (size == 0) || (we && f3[2]) || (off >= DEPTH*4);
        if (!err && (off % size != 0)) err = 1'b1;
        rd = 32'h0;
        if (!err) begin
            v = 32'h0;
            for (int k = 0; k < size; k++) v = v | (32'(bmem[int'(off) + k]) << (8*k));
            if (we) begin
                for (int k = 0; k < size; k++) bmem[int'(off) + k] = 8'(wd >> (8*k));
            end else begin
                if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                rd = v;
            end
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit use_exp = 1'b0,
                         input logic exp_err = 1'b0, input logic [31:0] exp_rd = 32'h0);
        logic        m_err;
        logic [31:0] m_rd;
        exp_t        e;
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wd;
        check_eq("req_ready", 32'(req_ready_o), 32'd1);
        if (req_ready_o === 1'b1) begin
            model_req(we, f3, addr, wd, m_err, m_rd);
            e.due   = cyc + int'(LAT);
            e.err   = use_exp ? exp_err : m_err;
            e.rdata = use_exp ? exp_rd : m_rd;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    // Called at the negedge where rst was dropped; counts edges until ready
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == int'(DEPTH) / 2) check_eq({tag, "_busy"}, 32'(busy_o), 32'd1);
        end while (req_ready_o !== 1'b1 && n < 100);
        req_valid_i = 1'b0;
        check_eq(tag, 32'(n), DEPTH);
        check_eq({tag, "_busy_end"}, 32'(busy_o), 32'd0);
        for (int i = 0; i < int'(DEPTH) * 4; i++) bmem[i] = 8'h00;
    endtask

    // Response monitor: exact-cycle match against the expected queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                cur_e = exp_q.pop_front();
                check_eq("rsp_valid", 32'(rsp_valid_o), 32'd1);
                check_eq("rsp_err", 32'(rsp_err_o), 32'(cur_e.err));
                check_eq("rsp_rdata", rsp_rdata_o, cur_e.rdata);
            end else begin
                check_eq("idle_valid", 32'(rsp_valid_o), 32'd0);
                check_eq("idle_err", 32'(rsp_err_o), 32'd0);
                check_eq("idle_rdata", rsp_rdata_o, 32'h0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        logic we;
        rst          = 1'b1;
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = F3_W;
        req_addr_i   = BASE;
        req_wdata_i  = 32'h0;
        for (int i = 0; i < int'(DEPTH) * 4; i++) bmem[i] = 8'h00;

        // Reset values, then clear length with req_valid held high
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        check_eq("rst_ready", 32'(req_ready_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        check_eq("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        rst = 1'b0;
        wait_clear("clear_cycles");

        issue(1'b0, F3_W, BASE + 32'h3C, 32'h0, 1'b1, 1'b0, 32'h0);
        issue(1'b0, F3_W, BASE + 32'h00, 32'h0, 1'b1, 1'b0, 32'h0);

        // Byte merge and sign/zero extension
        issue(1'b1, F3_W,  BASE + 32'h0, 32'h1122_3344);
        issue(1'b1, F3_B,  BASE + 32'h1, 32'h1234_56AB);
        issue(1'b0, F3_W,  BASE + 32'h0, 32'h0, 1'b1, 1'b0, 32'h1122_AB44);
        issue(1'b0, F3_B,  BASE + 32'h1, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFAB);
        issue(1'b0, F3_BU, BASE + 32'h1, 32'h0, 1'b1, 1'b0, 32'h0000_00AB);

        // Halfword
        issue(1'b1, F3_H,  BASE + 32'h6, 32'hDEAD_8001);
        issue(1'b0, F3_H,  BASE + 32'h6, 32'h0, 1'b1, 1'b0, 32'hFFFF_8001);
        issue(1'b0, F3_HU, BASE + 32'h6, 32'h0, 1'b1, 1'b0, 32'h0000_8001);
        issue(1'b0, F3_H,  BASE + 32'h5, 32'h0, 1'b1, 1'b1, 32'h0);

        // Errors leave memory untouched
        issue(1'b1, F3_W,   BASE + 32'h2,       32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0);
        issue(1'b1, F3_W,   BASE + DEPTH*4,     32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0);
        issue(1'b1, 3'b011, BASE + 32'h0,       32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0);
        issue(1'b0, F3_W,   BASE - 32'h4,       32'h0,         1'b1, 1'b1, 32'h0);
        issue(1'b0, 3'b110, BASE + 32'h0,       32'h0,         1'b1, 1'b1, 32'h0);
        issue(1'b0, F3_W,   BASE + 32'h0,       32'h0,         1'b1, 1'b0, 32'h1122_AB44);
        issue(1'b0, F3_W,   BASE + 32'h4,       32'h0,         1'b1, 1'b0, 32'h8001_0000);

        // Back-to-back store then load to the same word
        issue(1'b1, F3_W, BASE + 32'h8, 32'hCAFE_F00D);
        issue(1'b0, F3_W, BASE + 32'h8, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D);
        idle();

        // Randomized traffic with occasional bubbles and out-of-range addresses
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle();
            end else begin
                r  = int'($urandom_range(0, DEPTH*4 + 15)) - 8;
                we = 1'($urandom_range(0, 1));
                issue(we, 3'($urandom_range(0, 7)), BASE + 32'(r), $urandom());
            end
        end
        idle();
        repeat (int'(LAT) + 2) @(negedge clk);

        // Reset with two requests in flight, then reset again mid-clear
        issue(1'b1, F3_W, BASE + 32'h10, 32'h5555_AAAA);
        issue(1'b0, F3_W, BASE + 32'h10, 32'h0);
        @(negedge clk);
        rst         = 1'b1;
        req_valid_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_eq("midrst_busy", 32'(busy_o), 32'd1);
        check_eq("midrst_ready", 32'(req_ready_o), 32'd0);
        rst          = 1'b0;
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = F3_W;
        req_addr_i   = BASE;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_clear("clear_restart");
        issue(1'b0, F3_W, BASE + 32'h10, 32'h0, 1'b1, 1'b0, 32'h0);
        issue(1'b0, F3_W, BASE + 32'h00, 32'h0, 1'b1, 1'b0, 32'h0);
        idle();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
